// File: rtl/bsg_chip_hb_reset_sequencer_pkg.sv
// Shared types and defaults for the HammerBlade reset sequencer.
package bsg_chip_hb_reset_sequencer_pkg;

  localparam int wh_cord_width_gp        = 7;
  localparam int hb_seq_hold_cycles_gp   = 16;
  localparam int hb_seq_settle_cycles_gp = 8;

  typedef enum logic [1:0] {
    eRESET   = 2'd0,
    eLINK_UP = 2'd1,
    eRUN     = 2'd2,
    eDRAIN   = 2'd3
  } hb_reset_seq_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bsg_chip_hb_reset_sequencer_if.sv
// Tag-side requests, cord updates and sequenced reset/status outputs.
interface bsg_chip_hb_reset_sequencer_if
  #(parameter int cord_width_p = bsg_chip_hb_reset_sequencer_pkg::wh_cord_width_gp);

  logic                         tag_reset_i;
  logic [1:0][cord_width_p-1:0] dest_cord_i;
  logic [1:0]                   dest_cord_new_i;
  logic                         idle_i;
  logic                         link_reset_o;
  logic                         array_reset_o;
  logic [1:0][cord_width_p-1:0] dest_wh_cord_o;
  logic                         quiesce_o;
  logic                         ready_o;
  logic                         timeout_o;

  modport master (
    output tag_reset_i, dest_cord_i, dest_cord_new_i, idle_i,
    input  link_reset_o, array_reset_o, dest_wh_cord_o, quiesce_o, ready_o, timeout_o
  );

  modport slave (
    input  tag_reset_i, dest_cord_i, dest_cord_new_i, idle_i,
    output link_reset_o, array_reset_o, dest_wh_cord_o, quiesce_o, ready_o, timeout_o
  );

endinterface

// File: rtl/bsg_chip_hb_reset_sequencer_cord_shadow.sv
// One destination cord: shadow captures every strobe, output copies the
// shadow only while the array is held in reset.
module bsg_chip_hb_cord_shadow
  #(parameter int cord_width_p = 7)
  (input  logic                    clk_i,
   input  logic                    reset_n_i,
   input  logic                    load_i,
   input  logic [cord_width_p-1:0] cord_i,
   input  logic                    copy_i,
   output logic [cord_width_p-1:0] cord_o);

  logic [cord_width_p-1:0] shadow_q, shadow_d;
  logic [cord_width_p-1:0] out_q, out_d;

  // Output copies the pre-edge shadow, so a same-cycle strobe lands one cycle later.
  always_comb begin
    shadow_d = load_i ? cord_i : shadow_q;
    out_d    = copy_i ? shadow_q : out_q;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      shadow_q <= '0;
      out_q    <= '0;
    end else begin
      shadow_q <= shadow_d;
      out_q    <= out_d;
    end
  end

  assign cord_o = out_q;

endmodule

// File: rtl/bsg_chip_hb_reset_sequencer.sv
// Orders link/array reset release, drains traffic before run-time reset,
// and gates cord updates to reset. Optional drain watchdog: BSG_HB_RESET_SEQ_TIMEOUT_EN.
module bsg_chip_hb_reset_sequencer
  import bsg_chip_hb_reset_sequencer_pkg::*;
  #(parameter int cord_width_p    = wh_cord_width_gp,
    parameter int hold_cycles_p   = hb_seq_hold_cycles_gp,
    parameter int settle_cycles_p = hb_seq_settle_cycles_gp,
    parameter int drain_timeout_p = 1024)
  (input logic                         hb_clk_i,
   input logic                         reset_n_i,
   bsg_chip_hb_reset_sequencer_if.slave seq_if);

  localparam int CntMax = max3(hold_cycles_p, settle_cycles_p, drain_timeout_p);
  localparam int CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] HoldLast   = CntW'(hold_cycles_p - 1);
  localparam logic [CntW-1:0] SettleLast = CntW'(settle_cycles_p - 1);

  hb_reset_seq_state_e state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                link_reset_q, array_reset_q, quiesce_q, ready_q;

`ifdef BSG_HB_RESET_SEQ_TIMEOUT_EN
  localparam logic [CntW-1:0] TimeoutLast = CntW'(drain_timeout_p - 1);
  logic timeout_set;
  logic timeout_q, timeout_d;
`endif

  always_comb begin
    state_d = state_q;
`ifdef BSG_HB_RESET_SEQ_TIMEOUT_EN
    timeout_set = 1'b0;
`endif
    unique case (state_q)
      eRESET:   if (cnt_q >= HoldLast && !seq_if.tag_reset_i) state_d = eLINK_UP;
      eLINK_UP: begin
        if (seq_if.tag_reset_i)        state_d = eRESET;
        else if (cnt_q == SettleLast)  state_d = eRUN;
      end
      eRUN:     if (seq_if.tag_reset_i) state_d = eDRAIN;
      eDRAIN: begin
        if (seq_if.idle_i) state_d = eRESET;
`ifdef BSG_HB_RESET_SEQ_TIMEOUT_EN
        else if (cnt_q == TimeoutLast) begin
          state_d     = eRESET;
          timeout_set = 1'b1;
        end
`endif
      end
      default:  state_d = eRESET;
    endcase

    if (state_d != state_q) cnt_d = '0;
    else if (cnt_q != '1)   cnt_d = cnt_q + 1'b1;
    else                    cnt_d = cnt_q;
  end

  // Outputs are registered from the next state so they track state_q exactly.
  always_ff @(posedge hb_clk_i) begin
    if (!reset_n_i) begin
      state_q       <= eRESET;
      cnt_q         <= '0;
      link_reset_q  <= 1'b1;
      array_reset_q <= 1'b1;
      quiesce_q     <= 1'b0;
      ready_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      link_reset_q  <= (state_d == eRESET);
      array_reset_q <= (state_d == eRESET) || (state_d == eLINK_UP);
      quiesce_q     <= (state_d == eDRAIN);
      ready_q       <= (state_d == eRUN);
    end
  end

`ifdef BSG_HB_RESET_SEQ_TIMEOUT_EN
  assign timeout_d = timeout_q | timeout_set;

  always_ff @(posedge hb_clk_i) begin
    if (!reset_n_i) timeout_q <= 1'b0;
    else            timeout_q <= timeout_d;
  end

  assign seq_if.timeout_o = timeout_q;
`else
  assign seq_if.timeout_o = 1'b0;
`endif

  logic copy_en;
  assign copy_en = (state_q == eRESET);

  bsg_chip_hb_cord_shadow #(.cord_width_p(cord_width_p)) cord_w (
    .clk_i    (hb_clk_i),
    .reset_n_i(reset_n_i),
    .load_i   (seq_if.dest_cord_new_i[0]),
    .cord_i   (seq_if.dest_cord_i[0]),
    .copy_i   (copy_en),
    .cord_o   (seq_if.dest_wh_cord_o[0])
  );

  bsg_chip_hb_cord_shadow #(.cord_width_p(cord_width_p)) cord_e (
    .clk_i    (hb_clk_i),
    .reset_n_i(reset_n_i),
    .load_i   (seq_if.dest_cord_new_i[1]),
    .cord_i   (seq_if.dest_cord_i[1]),
    .copy_i   (copy_en),
    .cord_o   (seq_if.dest_wh_cord_o[1])
  );

  assign seq_if.link_reset_o  = link_reset_q;
  assign seq_if.array_reset_o = array_reset_q;
  assign seq_if.quiesce_o     = quiesce_q;
  assign seq_if.ready_o       = ready_q;

endmodule

// File: tb/tb_bsg_chip_hb_reset_sequencer.sv
// Directed bench for bsg_chip_hb_reset_sequencer (hold=16, settle=8, timeout=32).
module tb_bsg_chip_hb_reset_sequencer;
  import bsg_chip_hb_reset_sequencer_pkg::*;

  localparam int CW = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bsg_chip_hb_reset_sequencer_if #(.cord_width_p(CW)) sif ();

  bsg_chip_hb_reset_sequencer #(
    .cord_width_p   (CW),
    .hold_cycles_p  (16),
    .settle_cycles_p(8),
    .drain_timeout_p(32)
  ) dut (
    .hb_clk_i (clk),
    .reset_n_i(rst_n),
    .seq_if   (sif.slave)
  );

  int tests = 0;
  int fails = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 60 && !sif.ready_o; i++) step();
    tests++;
    if (sif.ready_o !== 1'b1) begin
      fails++;
      $display("FAIL wait_ready: ready_o=%b required 1 within 60 cycles", sif.ready_o);
    end
  endtask

  task automatic test_reset();
    logic [4:0] obs;
    sif.tag_reset_i = 1'b0; sif.idle_i = 1'b0;
    sif.dest_cord_new_i = '0; sif.dest_cord_i = '0;
    do_reset();
    obs = {sif.link_reset_o, sif.array_reset_o, sif.quiesce_o, sif.ready_o, sif.timeout_o};
    tests++;
    if (obs !== 5'b11000) begin
      fails++;
      $display("FAIL reset_outputs: {link,arr,q,rdy,to}=%b required 11000", obs);
    end
    tests++;
    if (sif.dest_wh_cord_o !== '0) begin
      fails++;
      $display("FAIL reset_cords: %h required 0", sif.dest_wh_cord_o);
    end
  endtask

  task automatic test_power_on();
    logic [2:0] obs, exp_v;
    do_reset();
    for (int c = 1; c <= 26; c++) begin
      step();
      exp_v = {(c < 16), (c < 24), (c >= 24)};
      obs   = {sif.link_reset_o, sif.array_reset_o, sif.ready_o};
      tests++;
      if (obs !== exp_v) begin
        fails++;
        $display("FAIL power_on c=%0d: {link,arr,rdy}=%b required %b", c, obs, exp_v);
      end
    end
  endtask

  task automatic test_cord_load();
    do_reset();
    sif.dest_cord_i[1] = 7'h1A;
    sif.dest_cord_new_i = 2'b10;
    step();
    sif.dest_cord_new_i = 2'b00;
    tests++;
    if (sif.dest_wh_cord_o[1] !== 7'h00) begin
      fails++;
      $display("FAIL cord_strobe_lag: %h required 00", sif.dest_wh_cord_o[1]);
    end
    step();
    tests++;
    if (sif.dest_wh_cord_o[1] !== 7'h1A) begin
      fails++;
      $display("FAIL cord_load_reset: %h required 1a", sif.dest_wh_cord_o[1]);
    end
    wait_ready();
    sif.dest_cord_i[1] = 7'h2B;
    sif.dest_cord_new_i = 2'b10;
    step();
    sif.dest_cord_new_i = 2'b00;
    for (int i = 0; i < 4; i++) step();
    tests++;
    if (sif.dest_wh_cord_o[1] !== 7'h1A) begin
      fails++;
      $display("FAIL cord_frozen_run: %h required 1a", sif.dest_wh_cord_o[1]);
    end
    sif.tag_reset_i = 1'b1; sif.idle_i = 1'b1;
    step();   // DRAIN
    step();   // RESET entered
    sif.tag_reset_i = 1'b0; sif.idle_i = 1'b0;
    tests++;
    if (sif.dest_wh_cord_o[1] !== 7'h1A) begin
      fails++;
      $display("FAIL cord_frozen_entry: %h required 1a", sif.dest_wh_cord_o[1]);
    end
    step();
    tests++;
    if (sif.dest_wh_cord_o !== {7'h2B, 7'h00}) begin
      fails++;
      $display("FAIL cord_reload: %h required %h", sif.dest_wh_cord_o, {7'h2B, 7'h00});
    end
  endtask

  task automatic test_drain();
    logic bad;
    do_reset();
    wait_ready();
    sif.tag_reset_i = 1'b1; sif.idle_i = 1'b0;
    step();
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (sif.quiesce_o !== 1'b1 || sif.link_reset_o !== 1'b0 || sif.ready_o !== 1'b0) bad = 1'b1;
      if (i == 4) sif.tag_reset_i = 1'b0;
      step();
    end
    tests++;
    if (bad !== 1'b0) begin
      fails++;
      $display("FAIL drain_hold: quiesce/reset error seen=%b required 0", bad);
    end
    sif.idle_i = 1'b1;
    tests++;
    if (sif.quiesce_o !== 1'b1) begin
      fails++;
      $display("FAIL drain_11th: quiesce_o=%b required 1", sif.quiesce_o);
    end
    step();
    sif.idle_i = 1'b0;
    tests++;
    if ({sif.link_reset_o, sif.array_reset_o, sif.quiesce_o, sif.ready_o, sif.timeout_o} !== 5'b11000) begin
      fails++;
      $display("FAIL drain_exit: {link,arr,q,rdy,to}=%b required 11000",
               {sif.link_reset_o, sif.array_reset_o, sif.quiesce_o, sif.ready_o, sif.timeout_o});
    end
  endtask

  task automatic test_abort_link_up();
    logic bad;
    do_reset();
    for (int i = 0; i < 40 && sif.link_reset_o; i++) step();
    step();
    step();
    tests++;
    if ({sif.link_reset_o, sif.array_reset_o} !== 2'b01) begin
      fails++;
      $display("FAIL abort_link_up_state: {link,arr}=%b required 01",
               {sif.link_reset_o, sif.array_reset_o});
    end
    sif.tag_reset_i = 1'b1;
    step();
    tests++;
    if ({sif.link_reset_o, sif.array_reset_o, sif.quiesce_o} !== 3'b110) begin
      fails++;
      $display("FAIL abort_reassert: {link,arr,q}=%b required 110",
               {sif.link_reset_o, sif.array_reset_o, sif.quiesce_o});
    end
    bad = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (sif.array_reset_o !== 1'b1 || sif.quiesce_o !== 1'b0) bad = 1'b1;
    end
    sif.tag_reset_i = 1'b0;
    tests++;
    if (bad !== 1'b0) begin
      fails++;
      $display("FAIL abort_hold: array drop or drain seen=%b required 0", bad);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    wait_ready();
    sif.tag_reset_i = 1'b1; sif.idle_i = 1'b0;
    step();
`ifdef BSG_HB_RESET_SEQ_TIMEOUT_EN
    for (int i = 0; i < 31; i++) step();
    tests++;
    if ({sif.quiesce_o, sif.timeout_o} !== 2'b10) begin
      fails++;
      $display("FAIL timeout_32nd: {q,to}=%b required 10", {sif.quiesce_o, sif.timeout_o});
    end
    step();
    tests++;
    if ({sif.link_reset_o, sif.quiesce_o, sif.timeout_o} !== 3'b101) begin
      fails++;
      $display("FAIL timeout_exit: {link,q,to}=%b required 101",
               {sif.link_reset_o, sif.quiesce_o, sif.timeout_o});
    end
    sif.tag_reset_i = 1'b0;
    do_reset();
    tests++;
    if (sif.timeout_o !== 1'b0) begin
      fails++;
      $display("FAIL timeout_clear: timeout_o=%b required 0", sif.timeout_o);
    end
`else
    for (int i = 0; i < 2000; i++) step();
    tests++;
    if ({sif.link_reset_o, sif.quiesce_o, sif.timeout_o} !== 3'b010) begin
      fails++;
      $display("FAIL no_timeout: {link,q,to}=%b required 010",
               {sif.link_reset_o, sif.quiesce_o, sif.timeout_o});
    end
    sif.tag_reset_i = 1'b0;
`endif
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    sif.dest_cord_i = {7'h15, 7'h15};
    sif.dest_cord_new_i = 2'b11;
    step();
    sif.dest_cord_new_i = 2'b00;
    wait_ready();
    sif.tag_reset_i = 1'b1; sif.idle_i = 1'b0;
    step();
    step();
    tests++;
    if ({sif.quiesce_o, sif.dest_wh_cord_o} !== {1'b1, 7'h15, 7'h15}) begin
      fails++;
      $display("FAIL mid_drain_setup: {q,cords}=%h required %h",
               {sif.quiesce_o, sif.dest_wh_cord_o}, {1'b1, 7'h15, 7'h15});
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    sif.tag_reset_i = 1'b0;
    tests++;
    if ({sif.link_reset_o, sif.array_reset_o, sif.quiesce_o, sif.ready_o, sif.timeout_o} !== 5'b11000 ||
        sif.dest_wh_cord_o !== '0) begin
      fails++;
      $display("FAIL mid_drain_reset: {link,arr,q,rdy,to}=%b cords=%h required 11000 and 0",
               {sif.link_reset_o, sif.array_reset_o, sif.quiesce_o, sif.ready_o, sif.timeout_o},
               sif.dest_wh_cord_o);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_power_on();
    test_cord_load();
    test_drain();
    test_abort_link_up();
    test_timeout();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
